// File: rtl/i2s_tx.sv
// i2s_tx: Philips-I2S serialiser for an external audio DAC.
//
// Takes one signed 16-bit sample per clkEn strobe and sends it as a
// 32-BCLK I2S frame. BCLK, LRCLK and SDATA are all generated from clk.
// The mono build sends the sample in both slots.
// The optional stereo build, enabled by defining I2S_TX_STEREO_EN, adds iInR,
// which is captured on the same strobe and sent in the right slot.
//
// Parameters
//   BCLK_DIV  clk cycles per BCLK half-period (>=1); frame = 32 BCLK
// Ports
//   clk, rst    system clock; asynchronous active-high reset
//   clkEn       sample strobe, iIn (and iInR) valid this cycle
//   iIn         left / mono sample
//   iInR        right sample (stereo build only)
//   oBclk       bit clock
//   oLrclk      word select, 0 = left, 1 = right
//   oSdata      serial data, MSB first, updated on BCLK falling edges
//   oTaken      pulse: pending sample moved into the frame shifter
//   oUnderrun   pulse: frame started without a new sample (last one repeats)
//   oOverrun    pulse: new sample replaced one that was never sent
module i2s_tx #(
  parameter int unsigned BCLK_DIV = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clkEn,
  input  logic signed [15:0] iIn,
`ifdef I2S_TX_STEREO_EN
  input  logic signed [15:0] iInR,
`endif
  output logic               oBclk,
  output logic               oLrclk,
  output logic               oSdata,
  output logic               oTaken,
  output logic               oUnderrun,
  output logic               oOverrun
);

  localparam int unsigned      DIV_W    = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

  logic [DIV_W-1:0] divCnt_q, divCnt_d;
  logic             bclk_q, bclk_d;
  logic             lrclk_q, lrclk_d;
  logic             sdata_q, sdata_d;
  logic [4:0]       bitCnt_q, bitCnt_d;
  logic [31:0]      shifter_q, shifter_d;
  logic [15:0]      hold_q, hold_d;
  logic             pending_q, pending_d;
  logic             taken_q, taken_d;
  logic             underrun_q, underrun_d;
  logic             overrun_q, overrun_d;
  logic [15:0]      holdR;

  logic divTerm;
  logic fallEv;
  logic frameLoad;

`ifdef I2S_TX_STEREO_EN
  logic [15:0] holdR_q, holdR_d;
  assign holdR = holdR_q;
`else
  assign holdR = hold_q;
`endif

  assign divTerm   = (divCnt_q == DIV_LAST);
  // A fall event is the terminal count while BCLK is currently high.
  assign fallEv    = divTerm && bclk_q;
  // Wrapping 31 -> 0 starts a new frame.
  assign frameLoad = fallEv && (bitCnt_q == 5'd31);

  always_comb begin
    divCnt_d   = divTerm ? '0 : divCnt_q + DIV_W'(1);
    bclk_d     = divTerm ? ~bclk_q : bclk_q;
    lrclk_d    = lrclk_q;
    sdata_d    = sdata_q;
    bitCnt_d   = bitCnt_q;
    shifter_d  = shifter_q;
    hold_d     = hold_q;
    pending_d  = pending_q;
    taken_d    = 1'b0;
    underrun_d = 1'b0;
    overrun_d  = 1'b0;
`ifdef I2S_TX_STEREO_EN
    holdR_d    = holdR_q;
`endif

    if (fallEv) begin
      bitCnt_d = bitCnt_q + 5'd1;
      // High for slots 15..30: LRCLK leads each word's MSB by one BCLK.
      lrclk_d  = (bitCnt_d >= 5'd15) && (bitCnt_d != 5'd31);
      if (frameLoad) begin
        // Uses the registered hold, so a same-cycle capture goes to the next frame.
        shifter_d  = {hold_q, holdR};
        taken_d    = pending_q;
        underrun_d = ~pending_q;
      end else begin
        shifter_d = {shifter_q[30:0], 1'b0};
      end
      sdata_d = shifter_d[31];
    end

    // Capture has priority over the load's clear so a coincident sample stays pending.
    if (clkEn) begin
      hold_d    = iIn;
`ifdef I2S_TX_STEREO_EN
      holdR_d   = iInR;
`endif
      pending_d = 1'b1;
      overrun_d = pending_q && !frameLoad;
    end else if (frameLoad) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      divCnt_q   <= '0;
      bclk_q     <= 1'b0;
      lrclk_q    <= 1'b0;
      sdata_q    <= 1'b0;
      bitCnt_q   <= 5'd31;
      shifter_q  <= '0;
      hold_q     <= '0;
      pending_q  <= 1'b0;
      taken_q    <= 1'b0;
      underrun_q <= 1'b0;
      overrun_q  <= 1'b0;
`ifdef I2S_TX_STEREO_EN
      holdR_q    <= '0;
`endif
    end else begin
      divCnt_q   <= divCnt_d;
      bclk_q     <= bclk_d;
      lrclk_q    <= lrclk_d;
      sdata_q    <= sdata_d;
      bitCnt_q   <= bitCnt_d;
      shifter_q  <= shifter_d;
      hold_q     <= hold_d;
      pending_q  <= pending_d;
      taken_q    <= taken_d;
      underrun_q <= underrun_d;
      overrun_q  <= overrun_d;
`ifdef I2S_TX_STEREO_EN
      holdR_q    <= holdR_d;
`endif
    end
  end

  assign oBclk     = bclk_q;
  assign oLrclk    = lrclk_q;
  assign oSdata    = sdata_q;
  assign oTaken    = taken_q;
  assign oUnderrun = underrun_q;
  assign oOverrun  = overrun_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Testbench for i2s_tx: two instances (BCLK_DIV=1 and 3) share stimulus.
// A frame-level reference model predicts every output from the clock-edge
// count since reset release and the list of captured samples.
module tb_i2s_tx;

  localparam int DA = 1;
  localparam int DB = 3;
  localparam int PB = 64 * DB;
`ifdef I2S_TX_STEREO_EN
  localparam bit STEREO = 1'b1;
`else
  localparam bit STEREO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clkEn = 1'b0;
  logic [15:0] iIn = '0;
  logic [15:0] iInR = '0;

  logic a_bclk, a_lr, a_sd, a_tk, a_ur, a_ov;
  logic b_bclk, b_lr, b_sd, b_tk, b_ur, b_ov;

  always #5 clk = ~clk;

  i2s_tx #(.BCLK_DIV(DA)) dut_a (
    .clk(clk), .rst(rst), .clkEn(clkEn), .iIn(iIn),
`ifdef I2S_TX_STEREO_EN
    .iInR(iInR),
`endif
    .oBclk(a_bclk), .oLrclk(a_lr), .oSdata(a_sd),
    .oTaken(a_tk), .oUnderrun(a_ur), .oOverrun(a_ov)
  );

  i2s_tx #(.BCLK_DIV(DB)) dut_b (
    .clk(clk), .rst(rst), .clkEn(clkEn), .iIn(iIn),
`ifdef I2S_TX_STEREO_EN
    .iInR(iInR),
`endif
    .oBclk(b_bclk), .oLrclk(b_lr), .oSdata(b_sd),
    .oTaken(b_tk), .oUnderrun(b_ur), .oOverrun(b_ov)
  );

  typedef struct {
    int          e;
    logic [15:0] l;
    logic [15:0] r;
  } cap_t;

  typedef struct packed {
    logic        ch;
    logic [15:0] w;
  } rx_t;

  cap_t caps[$];
  rx_t  rxq[$];
  int   n;
  int   checks;
  int   errors;
  int   a_tk_c, a_ur_c, a_ov_c, b_tk_c, b_ur_c, b_ov_c;

  // Frame j starts at edge 2*d*(32j+1) and carries the newest sample captured before it.
  function automatic logic [31:0] frame_word(input int j, input int d);
    int          ld;
    logic [31:0] w;
    ld = 2 * d * (32 * j + 1);
    w  = '0;
    foreach (caps[i])
      if (caps[i].e < ld) w = {caps[i].l, (STEREO ? caps[i].r : caps[i].l)};
    return w;
  endfunction

  function automatic int nloads(input int x, input int d);
    return (x < 2 * d) ? 0 : (x - 2 * d) / (64 * d) + 1;
  endfunction

  // Returns {bclk, lrclk, sdata, taken, underrun, overrun} after edge x.
  function automatic logic [5:0] model(input int x, input int d);
    logic        bclk, lr, sd, tk, ur, ov, pend;
    int          f, b, j;
    logic [31:0] w;
    bclk = ((x / d) % 2) == 1;
    lr = 1'b0; sd = 1'b0; tk = 1'b0; ur = 1'b0; ov = 1'b0;
    f = x / (2 * d);
    if (f > 0) begin
      b  = (f - 1) % 32;
      j  = (f - 1) / 32;
      lr = (b >= 15) && (b <= 30);
      w  = frame_word(j, d);
      sd = w[31 - b];
    end
    if (x > 0 && (x % (64 * d)) == 2 * d) begin
      pend = 1'b0;
      foreach (caps[i])
        if (caps[i].e >= x - 64 * d && caps[i].e < x) pend = 1'b1;
      tk = pend;
      ur = !pend;
    end
    if (x > 0 && caps.size() > 1 && caps[caps.size()-1].e == x)
      ov = (nloads(caps[caps.size()-2].e, d) == nloads(x, d));
    return {bclk, lr, sd, tk, ur, ov};
  endfunction

  // Cycle monitor, plus an I2S receiver on the BCLK_DIV=3 instance.
  logic [5:0]  ea, eb;
  logic        rx_pb, rx_plr, rx_ch;
  logic [15:0] rx_acc;
  always @(negedge clk) begin
    if (rst) begin
      ea = '0;
      eb = '0;
    end else begin
      ea = model(n, DA);
      eb = model(n, DB);
    end
    checks++;
    if ({a_bclk, a_lr, a_sd, a_tk, a_ur, a_ov} !== ea) begin
      errors++;
      $display("FAIL mon_div1 n=%0d got {bclk,lr,sd,tk,ur,ov}=%b expected=%b",
               n, {a_bclk, a_lr, a_sd, a_tk, a_ur, a_ov}, ea);
    end
    checks++;
    if ({b_bclk, b_lr, b_sd, b_tk, b_ur, b_ov} !== eb) begin
      errors++;
      $display("FAIL mon_div3 n=%0d got {bclk,lr,sd,tk,ur,ov}=%b expected=%b",
               n, {b_bclk, b_lr, b_sd, b_tk, b_ur, b_ov}, eb);
    end
    if (a_tk === 1'b1) a_tk_c++;
    if (a_ur === 1'b1) a_ur_c++;
    if (a_ov === 1'b1) a_ov_c++;
    if (b_tk === 1'b1) b_tk_c++;
    if (b_ur === 1'b1) b_ur_c++;
    if (b_ov === 1'b1) b_ov_c++;
    if (rst) begin
      rx_pb = 1'b0; rx_plr = 1'b0; rx_ch = 1'b0; rx_acc = '0;
    end else begin
      if (b_bclk && !rx_pb) begin
        rx_acc = {rx_acc[14:0], b_sd};
        // An LRCLK change marks the LSB of the word just finished.
        if (b_lr != rx_plr) begin
          rxq.push_back('{ch: rx_ch, w: rx_acc});
          rx_ch  = b_lr;
          rx_acc = '0;
        end
        rx_plr = b_lr;
      end
      rx_pb = b_bclk;
    end
  end

  task automatic step(input bit en, input logic [15:0] l, input logic [15:0] r);
    clkEn = en;
    iIn   = l;
    iInR  = r;
    @(posedge clk);
    if (!rst) begin
      n++;
      if (en) caps.push_back('{e: n, l: l, r: r});
    end
    #1;
    clkEn = 1'b0;
  endtask

  task automatic idle(input int k);
    repeat (k) step(1'b0, 16'($urandom), 16'($urandom));
  endtask

  task automatic align(input int ph);
    int guard = 0;
    while ((n % PB) != ph && guard < 2 * PB) begin
      idle(1);
      guard++;
    end
    checks++;
    if ((n % PB) != ph) begin
      errors++;
      $display("FAIL align phase got=%0d expected=%0d", n % PB, ph);
    end
  endtask

  task automatic clear_counts();
    a_tk_c = 0; a_ur_c = 0; a_ov_c = 0;
    b_tk_c = 0; b_ur_c = 0; b_ov_c = 0;
    rxq.delete();
  endtask

  function automatic bit has_pair(input logic [15:0] l, input logic [15:0] r);
    for (int i = 0; i + 1 < rxq.size(); i++)
      if (rxq[i].ch == 1'b0 && rxq[i].w == l && rxq[i+1].ch == 1'b1 && rxq[i+1].w == r)
        return 1'b1;
    return 1'b0;
  endfunction

  function automatic int find_left(input logic [15:0] l);
    for (int i = 0; i < rxq.size(); i++)
      if (rxq[i].ch == 1'b0 && rxq[i].w == l) return i;
    return -1;
  endfunction

  task automatic test_reset();
    int bq[$];
    int lq[$];
    logic pb, pl, anysd;
    rst = 1'b1;
    idle(3);
    checks++;
    if ({a_bclk, a_lr, a_sd, a_tk, a_ur, a_ov} !== 6'b0) begin
      errors++;
      $display("FAIL reset_div1 got=%b expected=000000", {a_bclk, a_lr, a_sd, a_tk, a_ur, a_ov});
    end
    checks++;
    if ({b_bclk, b_lr, b_sd, b_tk, b_ur, b_ov} !== 6'b0) begin
      errors++;
      $display("FAIL reset_div3 got=%b expected=000000", {b_bclk, b_lr, b_sd, b_tk, b_ur, b_ov});
    end
    n = 0;
    caps.delete();
    clear_counts();
    rst = 1'b0;
    pb = 1'b0; pl = 1'b0; anysd = 1'b0;
    for (int i = 0; i < 140; i++) begin
      idle(1);
      if (a_bclk && !pb) bq.push_back(n);
      if (a_lr && !pl) lq.push_back(n);
      if (n <= 65) anysd = anysd | a_sd;
      pb = a_bclk;
      pl = a_lr;
    end
    checks++;
    if (bq.size() < 2 || bq[1] - bq[0] != 2) begin
      errors++;
      $display("FAIL bclk_period got=%0d expected=2", (bq.size() < 2) ? -1 : bq[1] - bq[0]);
    end
    checks++;
    if (lq.size() < 2 || lq[1] - lq[0] != 64) begin
      errors++;
      $display("FAIL lrclk_period got=%0d expected=64", (lq.size() < 2) ? -1 : lq[1] - lq[0]);
    end
    checks++;
    if (anysd !== 1'b0) begin
      errors++;
      $display("FAIL first_frame_zero got sdata_seen=%b expected=0", anysd);
    end
    checks++;
    if (a_ur_c != 3 || a_tk_c != 0) begin
      errors++;
      $display("FAIL reset_underruns got ur=%0d tk=%0d expected ur=3 tk=0", a_ur_c, a_tk_c);
    end
  endtask

  task automatic test_pattern(input logic [15:0] l, input logic [15:0] r);
    logic [15:0] er;
    er = STEREO ? r : l;
    align(100);
    clear_counts();
    step(1'b1, l, r);
    idle(400);
    checks++;
    if (b_tk_c != 1 || b_ur_c != 1) begin
      errors++;
      $display("FAIL pattern_%h_pulses got tk=%0d ur=%0d expected tk=1 ur=1", l, b_tk_c, b_ur_c);
    end
    checks++;
    if (!has_pair(l, er)) begin
      errors++;
      $display("FAIL pattern_%h_words got words=%0d without pair expected L=%h R=%h",
               l, rxq.size(), l, er);
    end
  endtask

  task automatic test_underrun();
    int cnt = 0;
    align(100);
    clear_counts();
    step(1'b1, 16'h1234, 16'h4321);
    idle(4 * PB - 1);
    checks++;
    if (b_tk_c != 1 || b_ur_c != 3) begin
      errors++;
      $display("FAIL underrun_pulses got tk=%0d ur=%0d expected tk=1 ur=3", b_tk_c, b_ur_c);
    end
    foreach (rxq[i]) if (rxq[i].ch == 1'b0 && rxq[i].w == 16'h1234) cnt++;
    checks++;
    if (cnt < 3) begin
      errors++;
      $display("FAIL underrun_repeat got left_1234=%0d expected>=3", cnt);
    end
  endtask

  task automatic test_overrun();
    align(100);
    clear_counts();
    step(1'b1, 16'h1111, 16'h0101);
    step(1'b1, 16'h2222, 16'h0202);
    idle(400);
    checks++;
    if (a_ov_c != 1 || b_ov_c != 1) begin
      errors++;
      $display("FAIL overrun_pulses got div1=%0d div3=%0d expected 1 and 1", a_ov_c, b_ov_c);
    end
    checks++;
    if (find_left(16'h2222) < 0 || find_left(16'h1111) >= 0) begin
      errors++;
      $display("FAIL overrun_words got idx2222=%0d idx1111=%0d expected >=0 and -1",
               find_left(16'h2222), find_left(16'h1111));
    end
  endtask

  task automatic test_coincident();
    int ia, ib;
    align(100);
    clear_counts();
    step(1'b1, 16'hAAAA, 16'hA0A0);
    align(5);
    step(1'b1, 16'h5555, 16'h5050);
    idle(400);
    checks++;
    if (b_tk_c != 2 || b_ov_c != 0) begin
      errors++;
      $display("FAIL coincident_pulses got tk=%0d ov=%0d expected tk=2 ov=0", b_tk_c, b_ov_c);
    end
    ia = find_left(16'hAAAA);
    ib = find_left(16'h5555);
    checks++;
    if (ia < 0 || ib <= ia) begin
      errors++;
      $display("FAIL coincident_order got idxAAAA=%0d idx5555=%0d expected 0<=a<b", ia, ib);
    end
  endtask

  task automatic test_random();
    int first, expov;
    clear_counts();
    first = caps.size();
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 149) == 0, 16'($urandom), 16'($urandom));
    idle(5);
    expov = 0;
    for (int i = first; i < caps.size(); i++)
      if (i > 0 && nloads(caps[i-1].e, DB) == nloads(caps[i].e, DB)) expov++;
    checks++;
    if (b_ov_c != expov) begin
      errors++;
      $display("FAIL random_overruns got=%0d expected=%0d", b_ov_c, expov);
    end
  endtask

  task automatic test_reset_mid();
    align(128);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({a_bclk, a_lr, a_sd, a_tk, a_ur, a_ov, b_bclk, b_lr, b_sd, b_tk, b_ur, b_ov} !== 12'b0) begin
      errors++;
      $display("FAIL midreset_async got=%b expected=0",
               {a_bclk, a_lr, a_sd, a_tk, a_ur, a_ov, b_bclk, b_lr, b_sd, b_tk, b_ur, b_ov});
    end
    n = 0;
    caps.delete();
    idle(2);
    clear_counts();
    rst = 1'b0;
    idle(190);
    checks++;
    if (b_ur_c != 1 || b_tk_c != 0 || a_ur_c != 3) begin
      errors++;
      $display("FAIL midreset_restart got div3 ur=%0d tk=%0d div1 ur=%0d expected 1 0 3",
               b_ur_c, b_tk_c, a_ur_c);
    end
  endtask

  initial begin
    n = 0;
    checks = 0;
    errors = 0;
    test_reset();
    test_pattern(16'h8001, 16'h0FF0);
    test_underrun();
    test_overrun();
    test_coincident();
    test_pattern(16'h7FFF, 16'h8000);
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout expected=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
